// File: rtl/imm_decode_stage_pkg.sv
// Shared types and opcode constants for the registered immediate-decode stage.
package imm_decode_stage_pkg;

    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } inst_format_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Upstream/downstream handshake bundle of the immediate-decode stage, plus flush.
interface imm_decode_stage_if
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    inst_format_t     out_fmt;
    logic [XLEN-1:0]  out_imm;
    logic             out_illegal;
    logic [31:0]      out_inst;
    logic [TAG_W-1:0] out_tag;

    // Fetch side plus execute side, seen from outside the stage
    modport master (
        output flush, in_valid, in_inst, in_tag, out_ready,
        input  in_ready, out_valid, out_fmt, out_imm, out_illegal, out_inst, out_tag
    );

    modport slave (
        input  flush, in_valid, in_inst, in_tag, out_ready,
        output in_ready, out_valid, out_fmt, out_imm, out_illegal, out_inst, out_tag
    );
endinterface

// File: rtl/imm_decode_stage_imm_extract.sv
// Combinational format classifier and immediate builder.
// ZICSR_IMM_EN: CSR*I instructions yield the 5-bit zimm instead of the CSR address.
module imm_extract
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output inst_format_t    fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);
    logic [6:0]      opc;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] shamt5, shamt_opimm;

    assign opc    = inst[6:0];
    assign funct3 = inst[14:12];

    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    // Shift immediates carry funct7/funct6 in the upper field; only shamt is exposed
    assign is_shift    = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign shamt5      = XLEN'(inst[24:20]);
    assign shamt_opimm = (XLEN == 64) ? XLEN'(inst[25:20]) : shamt5;

    always_comb begin
        fmt     = R_TYPE;
        imm     = '0;
        illegal = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                fmt = U_TYPE;
                imm = imm_u;
            end
            OPC_JAL: begin
                fmt = J_TYPE;
                imm = imm_j;
            end
            OPC_JALR, OPC_LOAD, OPC_MISC_MEM: begin
                fmt = I_TYPE;
                imm = imm_i;
            end
            OPC_OP_IMM: begin
                fmt = I_TYPE;
                imm = is_shift ? shamt_opimm : imm_i;
            end
            OPC_SYSTEM: begin
                fmt = I_TYPE;
`ifdef ZICSR_IMM_EN
                imm = funct3[2] ? XLEN'(inst[19:15]) : imm_i;
`else
                imm = imm_i;
`endif
            end
            OPC_STORE: begin
                fmt = S_TYPE;
                imm = imm_s;
            end
            OPC_BRANCH: begin
                fmt = B_TYPE;
                imm = imm_b;
            end
            OPC_OP: fmt = R_TYPE;
            OPC_OP_IMM32: begin
                if (XLEN == 64) begin
                    fmt = I_TYPE;
                    imm = is_shift ? shamt5 : imm_i;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP32: illegal = (XLEN != 64);
            default:  illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: imm_extract followed by a main register and a
// one-entry skid register behind valid/ready. Optional ZICSR_IMM_EN (see imm_extract).
module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input logic              clk,
    input logic              rst,
    imm_decode_stage_if.slave bus
);
    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        inst_format_t     fmt;
        logic [XLEN-1:0]  imm;
        logic             illegal;
        logic [31:0]      inst;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t          main_q, skid_q, new_e;
    logic            main_vld, skid_vld;
    logic            accept, main_free;
    inst_format_t    dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .inst    (bus.in_inst),
        .fmt     (dec_fmt),
        .imm     (dec_imm),
        .illegal (dec_ill)
    );

    assign new_e     = '{fmt: dec_fmt, imm: dec_imm, illegal: dec_ill,
                         inst: bus.in_inst, tag: bus.in_tag};
    assign accept    = bus.in_valid && !skid_vld;
    assign main_free = !main_vld || bus.out_ready;

    // skid only fills while main is held, so a full skid implies a full main
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (bus.flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (main_free) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else if (accept) begin
                main_q   <= new_e;
                main_vld <= 1'b1;
            end else begin
                main_vld <= 1'b0;
            end
        end else if (accept) begin
            skid_q   <= new_e;
            skid_vld <= 1'b1;
        end
    end

    assign bus.in_ready    = !skid_vld;
    assign bus.out_valid   = main_vld;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_illegal = main_q.illegal;
    assign bus.out_inst    = main_q.inst;
    assign bus.out_tag     = main_q.tag;
endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: decode table on XLEN=32/64 instances, then
// backpressure, flush, reset-priority and random-stall scoreboard sequences on XLEN=32.
module tb_imm_decode_stage;
    import imm_decode_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imm_decode_stage_if #(.XLEN(32), .TAG_W(32)) if32 ();
    imm_decode_stage_if #(.XLEN(64), .TAG_W(32)) if64 ();

    imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
    imm_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst(rst), .bus(if64));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0]  inst;
        inst_format_t fmt32;
        inst_format_t fmt64;
        logic         ill32;
        logic         ill64;
        logic [31:0]  imm32;
        logic [63:0]  imm64;
    } vec_t;

    localparam int NV = 18;
`ifdef ZICSR_IMM_EN
    localparam logic [63:0] CSR_IMM = 64'd5;
`else
    localparam logic [63:0] CSR_IMM = 64'd0;
`endif

    vec_t vt[NV];
    int   q[$];
    int   next_k, got, k;

    initial begin
        vt[0]  = '{32'h0FF00093, I_TYPE, I_TYPE, 1'b0, 1'b0, 32'h000000FF, 64'h00000000000000FF};
        vt[1]  = '{32'hFE000EE3, B_TYPE, B_TYPE, 1'b0, 1'b0, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
        vt[2]  = '{32'h800000B7, U_TYPE, U_TYPE, 1'b0, 1'b0, 32'h80000000, 64'hFFFFFFFF80000000};
        vt[3]  = '{32'h4200D093, I_TYPE, I_TYPE, 1'b0, 1'b0, 32'h00000000, 64'h0000000000000020};
        vt[4]  = '{32'h40205093, I_TYPE, I_TYPE, 1'b0, 1'b0, 32'h00000002, 64'h0000000000000002};
        vt[5]  = '{32'h0002D073, I_TYPE, I_TYPE, 1'b0, 1'b0, CSR_IMM[31:0], CSR_IMM};
        vt[6]  = '{32'h0000007F, R_TYPE, R_TYPE, 1'b1, 1'b1, 32'h00000000, 64'h0000000000000000};
        vt[7]  = '{32'hFE112E23, S_TYPE, S_TYPE, 1'b0, 1'b0, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
        vt[8]  = '{32'h008000EF, J_TYPE, J_TYPE, 1'b0, 1'b0, 32'h00000008, 64'h0000000000000008};
        vt[9]  = '{32'h002081B3, R_TYPE, R_TYPE, 1'b0, 1'b0, 32'h00000000, 64'h0000000000000000};
        vt[10] = '{32'h12345097, U_TYPE, U_TYPE, 1'b0, 1'b0, 32'h12345000, 64'h0000000012345000};
        vt[11] = '{32'hFFF0809B, R_TYPE, I_TYPE, 1'b1, 1'b0, 32'h00000000, 64'hFFFFFFFFFFFFFFFF};
        vt[12] = '{32'h0020803B, R_TYPE, R_TYPE, 1'b1, 1'b0, 32'h00000000, 64'h0000000000000000};
        vt[13] = '{32'h80012083, I_TYPE, I_TYPE, 1'b0, 1'b0, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800};
        vt[14] = '{32'h03F09093, I_TYPE, I_TYPE, 1'b0, 1'b0, 32'h0000001F, 64'h000000000000003F};
        vt[15] = '{32'h0FF0000F, I_TYPE, I_TYPE, 1'b0, 1'b0, 32'h000000FF, 64'h00000000000000FF};
        vt[16] = '{32'h000080E7, I_TYPE, I_TYPE, 1'b0, 1'b0, 32'h00000000, 64'h0000000000000000};
        vt[17] = '{32'h4250D09B, R_TYPE, I_TYPE, 1'b1, 1'b0, 32'h00000000, 64'h0000000000000005};

        rst = 1'b1;
        if32.flush = 1'b0; if32.in_valid = 1'b0; if32.in_inst = '0; if32.in_tag = '0; if32.out_ready = 1'b0;
        if64.flush = 1'b0; if64.in_valid = 1'b0; if64.in_inst = '0; if64.in_tag = '0; if64.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_out_valid", 64'(if32.out_valid), 64'd0);
        chk("rst_in_ready", 64'(if32.in_ready), 64'd1);
        chk("rst_fmt", 64'(if32.out_fmt), 64'(R_TYPE));
        chk("rst_imm", 64'(if32.out_imm), 64'd0);
        chk("rst_illegal", 64'(if32.out_illegal), 64'd0);
        chk("rst_inst", 64'(if32.out_inst), 64'd0);
        chk("rst_tag", 64'(if32.out_tag), 64'd0);
        chk("rst_imm64", if64.out_imm, 64'd0);

        // Decode table, back-to-back at full throughput
        if32.out_ready = 1'b1;
        if64.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            if32.in_valid = 1'b1; if32.in_inst = vt[i].inst; if32.in_tag = 32'h1000 + 32'(i * 4);
            if64.in_valid = 1'b1; if64.in_inst = vt[i].inst; if64.in_tag = 32'h1000 + 32'(i * 4);
            tick();
            chk($sformatf("v%0d_valid32", i), 64'(if32.out_valid), 64'd1);
            chk($sformatf("v%0d_ready32", i), 64'(if32.in_ready), 64'd1);
            chk($sformatf("v%0d_fmt32", i), 64'(if32.out_fmt), 64'(vt[i].fmt32));
            chk($sformatf("v%0d_imm32", i), 64'(if32.out_imm), 64'(vt[i].imm32));
            chk($sformatf("v%0d_ill32", i), 64'(if32.out_illegal), 64'(vt[i].ill32));
            chk($sformatf("v%0d_inst32", i), 64'(if32.out_inst), 64'(vt[i].inst));
            chk($sformatf("v%0d_tag32", i), 64'(if32.out_tag), 64'(32'h1000 + 32'(i * 4)));
            chk($sformatf("v%0d_valid64", i), 64'(if64.out_valid), 64'd1);
            chk($sformatf("v%0d_fmt64", i), 64'(if64.out_fmt), 64'(vt[i].fmt64));
            chk($sformatf("v%0d_imm64", i), if64.out_imm, vt[i].imm64);
            chk($sformatf("v%0d_ill64", i), 64'(if64.out_illegal), 64'(vt[i].ill64));
        end
        if32.in_valid = 1'b0;
        if64.in_valid = 1'b0;
        tick();
        chk("drain_valid32", 64'(if32.out_valid), 64'd0);
        chk("drain_valid64", 64'(if64.out_valid), 64'd0);

        // Backpressure: 3 inputs, downstream stalled two cycles
        if32.out_ready = 1'b0;
        if32.in_valid = 1'b1; if32.in_inst = 32'h00100093; if32.in_tag = 32'h100;
        tick();
        chk("bp1_valid", 64'(if32.out_valid), 64'd1);
        chk("bp1_tag", 64'(if32.out_tag), 64'h100);
        chk("bp1_ready", 64'(if32.in_ready), 64'd1);
        if32.in_inst = 32'h00200093; if32.in_tag = 32'h104;
        tick();
        chk("bp2_ready", 64'(if32.in_ready), 64'd0);
        chk("bp2_tag", 64'(if32.out_tag), 64'h100);
        if32.in_inst = 32'h00300093; if32.in_tag = 32'h108;
        tick();
        chk("bp3_ready", 64'(if32.in_ready), 64'd0);
        chk("bp3_tag", 64'(if32.out_tag), 64'h100);
        chk("bp3_imm", 64'(if32.out_imm), 64'd1);
        if32.out_ready = 1'b1;
        tick();
        chk("bp4_valid", 64'(if32.out_valid), 64'd1);
        chk("bp4_tag", 64'(if32.out_tag), 64'h104);
        chk("bp4_imm", 64'(if32.out_imm), 64'd2);
        chk("bp4_ready", 64'(if32.in_ready), 64'd1);
        tick();
        chk("bp5_tag", 64'(if32.out_tag), 64'h108);
        chk("bp5_imm", 64'(if32.out_imm), 64'd3);
        if32.in_valid = 1'b0;
        tick();
        chk("bp6_valid", 64'(if32.out_valid), 64'd0);

        // Flush with main and skid both full, upstream still valid
        if32.out_ready = 1'b0;
        if32.in_valid = 1'b1; if32.in_tag = 32'h200;
        tick();
        if32.in_tag = 32'h204;
        tick();
        chk("fl_full_ready", 64'(if32.in_ready), 64'd0);
        if32.flush = 1'b1; if32.in_tag = 32'h208;
        tick();
        chk("fl_valid", 64'(if32.out_valid), 64'd0);
        chk("fl_ready", 64'(if32.in_ready), 64'd1);
        if32.flush = 1'b0; if32.in_valid = 1'b0; if32.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fl_quiet%0d", i), 64'(if32.out_valid), 64'd0);
        end

        // Flush while an input handshake happens: that entry is dropped too
        if32.out_ready = 1'b0;
        if32.in_valid = 1'b1; if32.in_tag = 32'h300;
        tick();
        if32.flush = 1'b1; if32.in_tag = 32'h304;
        tick();
        chk("flh_valid", 64'(if32.out_valid), 64'd0);
        chk("flh_ready", 64'(if32.in_ready), 64'd1);
        if32.flush = 1'b0; if32.in_valid = 1'b0; if32.out_ready = 1'b1;
        tick();
        chk("flh_quiet", 64'(if32.out_valid), 64'd0);

        // Reset wins over flush and clears the data registers
        if32.out_ready = 1'b0;
        if32.in_valid = 1'b1; if32.in_inst = 32'h0FF00093; if32.in_tag = 32'h400;
        tick();
        rst = 1'b1; if32.flush = 1'b1;
        tick();
        rst = 1'b0; if32.flush = 1'b0; if32.in_valid = 1'b0;
        chk("rp_valid", 64'(if32.out_valid), 64'd0);
        chk("rp_tag", 64'(if32.out_tag), 64'd0);
        chk("rp_imm", 64'(if32.out_imm), 64'd0);
        chk("rp_inst", 64'(if32.out_inst), 64'd0);

        // Random-stall scoreboard: 40 tagged addi entries, order and count checked
        next_k = 0;
        got    = 0;
        for (int c = 0; c < 600; c++) begin
            if32.in_valid  = (next_k < 40) && ($urandom_range(0, 3) != 0);
            if32.in_inst   = {12'(next_k), 5'd0, 3'd0, 5'd1, 7'h13};
            if32.in_tag    = 32'h2000 + 32'(next_k);
            if32.out_ready = ($urandom_range(0, 2) != 0);
            if (if32.out_valid && if32.out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_spurious", 64'd1, 64'd0);
                end else begin
                    k = q.pop_front();
                    chk("sb_tag", 64'(if32.out_tag), 64'(32'h2000 + 32'(k)));
                    chk("sb_imm", 64'(if32.out_imm), 64'(k));
                    got++;
                end
            end
            if (if32.in_valid && if32.in_ready) begin
                q.push_back(next_k);
                next_k++;
            end
            tick();
            if (next_k == 40 && q.size() == 0) break;
        end
        if32.in_valid = 1'b0;
        if32.out_ready = 1'b1;
        tick();
        chk("sb_count", 64'(got), 64'd40);
        chk("sb_empty", 64'(if32.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
